// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - cubic Horner evaluator, Q24.8 in / Q56.8 out, one multiply-add per cycle
// Build option: define SATURATE_EN to clamp out-of-range steps; otherwise steps wrap to 64 bits.
module poly_horner_eval #(
  parameter logic signed [31:0] C3 = 32'sh0000_0100,
  parameter logic signed [31:0] C2 = 32'sh0000_0200,
  parameter logic signed [31:0] C1 = 32'sh0000_0300,
  parameter logic signed [31:0] C0 = 32'sh0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_func,
  input  logic [31:0] x_in,
  output logic [63:0] y_out,
  output logic        func_done,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic signed [63:0] ACC_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] ACC_MIN = 64'sh8000_0000_0000_0000;

  state_t             r_state;
  state_t             w_next_state;
  logic signed [63:0] r_acc;
  logic signed [31:0] r_x;
  logic [1:0]         r_step;
  logic               r_ovf;
  logic [63:0]        r_y;
  logic               r_ovf_out;

  logic signed [31:0] w_coef;
  logic signed [95:0] w_prod;
  logic signed [96:0] w_sum;
  logic               w_in_range;
  logic signed [63:0] w_acc_next;
  logic               w_last;

  // Coefficient applied by the current Horner step (C3 is preloaded into acc)
  always_comb begin
    w_coef = C0;
    case (r_step)
      2'd0:    w_coef = C2;
      2'd1:    w_coef = C1;
      default: w_coef = C0;
    endcase
  end

  // Full-width product and sum so that range detection sees every bit
  assign w_prod     = 96'(r_acc) * 96'(r_x);
  assign w_sum      = 97'(w_prod >>> 8) + 97'(w_coef);
  assign w_in_range = (w_sum[96:63] == {34{w_sum[63]}});
  // Steps 0..2 compute; the cycle with step==3 publishes the result
  assign w_last     = (r_step == 2'd3);

  // Value written back to acc when the sum does not fit in 64 bits
  always_comb begin
    w_acc_next = w_sum[63:0];
    if (!w_in_range) begin
`ifdef SATURATE_EN
      w_acc_next = w_sum[96] ? ACC_MIN : ACC_MAX;
`else
      w_acc_next = w_sum[63:0];
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode: start is a level, DONE waits for it to drop
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_func) w_next_state = S_CALC;
      S_CALC:  if (w_last)     w_next_state = S_DONE;
      S_DONE:  if (!start_func) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy      = 1'b0;
    func_done = 1'b0;
    case (r_state)
      S_CALC:  busy      = 1'b1;
      S_DONE:  func_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, Horner accumulation and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_x       <= '0;
      r_step    <= '0;
      r_ovf     <= 1'b0;
      r_y       <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_func) begin
            r_x    <= x_in;
            r_acc  <= 64'(C3);
            r_step <= '0;
            r_ovf  <= 1'b0;
          end
        end
        S_CALC: begin
          if (w_last) begin
            r_y       <= r_acc;
            r_ovf_out <= r_ovf;
          end else begin
            r_acc  <= w_acc_next;
            r_step <= r_step + 2'd1;
            if (!w_in_range) r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign y_out    = r_y;
  assign overflow = r_ovf_out;

endmodule
